// File: rtl/access_ctrl_pkg.sv
// Shared definitions for the access-policy sequencer.
// Holds the FSM state encoding, the vga_status codes that the VGA status
// renderer decodes, and the ms-per-second constant used for lockout timing.
package access_ctrl_pkg;

    typedef enum logic [2:0] {
        S_SETUP   = 3'd0,
        S_IDLE    = 3'd1,
        S_GRANTED = 3'd2,
        S_DENIED  = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    // vga_status codes, shared with the VGA renderer.
    localparam logic [1:0] ST_NEUTRAL = 2'd0;
    localparam logic [1:0] ST_GREEN   = 2'd1;
    localparam logic [1:0] ST_RED     = 2'd2;
    localparam logic [1:0] ST_LOCK    = 2'd3;

    localparam int MS_PER_S = 1000;

    // Display code shown while the sequencer sits in a given state.
    function automatic logic [1:0] status_of(state_t s);
        case (s)
            S_GRANTED: return ST_GREEN;
            S_DENIED:  return ST_RED;
            S_LOCKED:  return ST_LOCK;
            default:   return ST_NEUTRAL;
        endcase
    endfunction

endpackage

// File: rtl/access_ctrl_tick_gen.sv
// Millisecond prescaler.
// Counts enabled clk cycles and raises tick for one cycle on every
// TICK_DIV-th enabled cycle. clear restarts the count so the first tick
// after a clear arrives exactly TICK_DIV enabled cycles later.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   clear      - synchronous restart of the prescaler
//   en         - count enable (prescaler holds when low)
//   tick       - one-cycle pulse at the end of each TICK_DIV period
module access_ctrl_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Combinational from the count register only, so the FSM may derive
    // clear from a next-state that depends on tick without forming a loop.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/access_ctrl.sv
// Access-policy sequencer between the password datapath and the VGA
// status renderer. Gates digit entry and password storage, times the
// green/red result display, counts consecutive failures and enforces a
// timed lockout. Sole driver of vga_status.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   verify_req          - pulse: entered code submitted
//   verify_match        - compare result, qualified by verify_req
//   pw_set_req          - pulse: user asks to change the password
//   set_done            - pulse: new password stored by the datapath
//   entry_en, set_en    - datapath permissions
//   vga_status          - 0 neutral, 1 green, 2 red, 3 locked
//   locked, lock_secs   - lockout flag and remaining seconds
//   fail_cnt            - consecutive-failure count
// All outputs come straight from flops; each reflects the input cycle
// before it.
module access_ctrl
    import access_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GRANT_MS = 2000,
    parameter int DENY_MS  = 1000,
    parameter int LOCK_S   = 30,
    parameter int MAX_FAIL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       verify_req,
    input  logic       verify_match,
    input  logic       pw_set_req,
    input  logic       set_done,
    output logic       entry_en,
    output logic       set_en,
    output logic [1:0] vga_status,
    output logic       locked,
    output logic [7:0] lock_secs,
    output logic [3:0] fail_cnt
);

    localparam int MS_GD  = (GRANT_MS > DENY_MS) ? GRANT_MS : DENY_MS;
    localparam int MS_MAX = (MS_GD > MS_PER_S) ? MS_GD : MS_PER_S;
    localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    localparam logic [MS_W-1:0] GRANT_LAST = MS_W'(GRANT_MS - 1);
    localparam logic [MS_W-1:0] DENY_LAST  = MS_W'(DENY_MS - 1);
    localparam logic [MS_W-1:0] SEC_LAST   = MS_W'(MS_PER_S - 1);

    state_t          state, state_nxt;
    logic [MS_W-1:0] ms_cnt, ms_nxt;
    logic [3:0]      fail_nxt;
    logic [7:0]      secs_nxt;
    logic            entry_nxt, set_nxt, locked_nxt;
    logic [1:0]      vga_nxt;
    logic            tick, timer_clr, timer_en;

    // The prescaler only runs in timed states and restarts on every state
    // change, so each display/lockout interval is measured from entry.
    assign timer_en  = (state == S_GRANTED) || (state == S_DENIED) ||
                       (state == S_LOCKED);
    assign timer_clr = (state_nxt != state);

    access_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clr),
        .en    (timer_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_SETUP;
            ms_cnt     <= '0;
            fail_cnt   <= 4'd0;
            lock_secs  <= 8'd0;
            entry_en   <= 1'b1;
            set_en     <= 1'b1;
            vga_status <= ST_NEUTRAL;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            ms_cnt     <= ms_nxt;
            fail_cnt   <= fail_nxt;
            lock_secs  <= secs_nxt;
            entry_en   <= entry_nxt;
            set_en     <= set_nxt;
            vga_status <= vga_nxt;
            locked     <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ms_nxt    = ms_cnt;
        fail_nxt  = fail_cnt;
        secs_nxt  = lock_secs;

        case (state)
            S_SETUP: begin
                if (set_done) begin
                    state_nxt = S_IDLE;
                    fail_nxt  = 4'd0;
                end
            end
            S_IDLE: begin
                if (verify_req) begin
                    if (verify_match) begin
                        state_nxt = S_GRANTED;
                        fail_nxt  = 4'd0;
                    end else if (({1'b0, fail_cnt} + 5'd1) < 5'(MAX_FAIL)) begin
                        state_nxt = S_DENIED;
                        fail_nxt  = fail_cnt + 4'd1;
                    end else begin
                        // Saturates at MAX_FAIL rather than incrementing.
                        state_nxt = S_LOCKED;
                        fail_nxt  = 4'(MAX_FAIL);
                        secs_nxt  = 8'(LOCK_S);
                    end
                end
            end
            S_GRANTED: begin
                // A simultaneous verify_req suppresses the set request.
                if (pw_set_req && !verify_req) begin
                    state_nxt = S_SETUP;
                end else if (tick) begin
                    if (ms_cnt == GRANT_LAST) state_nxt = S_IDLE;
                    else                      ms_nxt    = ms_cnt + 1'b1;
                end
            end
            S_DENIED: begin
                if (tick) begin
                    if (ms_cnt == DENY_LAST) state_nxt = S_IDLE;
                    else                     ms_nxt    = ms_cnt + 1'b1;
                end
            end
            S_LOCKED: begin
                if (tick) begin
                    if (ms_cnt == SEC_LAST) begin
                        ms_nxt = '0;
                        if (lock_secs <= 8'd1) begin
                            state_nxt = S_IDLE;
                            fail_nxt  = 4'd0;
                        end else begin
                            secs_nxt = lock_secs - 8'd1;
                        end
                    end else begin
                        ms_nxt = ms_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_SETUP;
                fail_nxt  = 4'd0;
            end
        endcase

        if (state_nxt != state) ms_nxt = '0;
        if (state_nxt != S_LOCKED) secs_nxt = 8'd0;

        entry_nxt  = (state_nxt == S_SETUP) || (state_nxt == S_IDLE);
        set_nxt    = (state_nxt == S_SETUP);
        locked_nxt = (state_nxt == S_LOCKED);
        vga_nxt    = status_of(state_nxt);
    end

endmodule

// File: tb/tb_access_ctrl.sv
// Bench for access_ctrl: directed steps followed by randomized requests,
// every cycle checked against a countdown-based reference model.
module tb_access_ctrl;

    localparam int TICK_DIV = 10;
    localparam int GRANT_MS = 3;
    localparam int DENY_MS  = 2;
    localparam int LOCK_S   = 2;
    localparam int MAX_FAIL = 3;

    localparam int GRANT_CYC = GRANT_MS * TICK_DIV;
    localparam int DENY_CYC  = DENY_MS * TICK_DIV;
    localparam int CPS       = 1000 * TICK_DIV;
    localparam int LOCK_CYC  = LOCK_S * CPS;

    localparam int M_SETUP = 0;
    localparam int M_IDLE  = 1;
    localparam int M_GRANT = 2;
    localparam int M_DENY  = 3;
    localparam int M_LOCK  = 4;

    logic       clk;
    logic       rst;
    logic       verify_req, verify_match, pw_set_req, set_done;
    logic       entry_en, set_en, locked;
    logic [1:0] vga_status;
    logic [7:0] lock_secs;
    logic [3:0] fail_cnt;
    logic [16:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_mode, m_fail, m_left;
    int locks;
    int n;

    access_ctrl #(
        .TICK_DIV (TICK_DIV),
        .GRANT_MS (GRANT_MS),
        .DENY_MS  (DENY_MS),
        .LOCK_S   (LOCK_S),
        .MAX_FAIL (MAX_FAIL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .verify_req   (verify_req),
        .verify_match (verify_match),
        .pw_set_req   (pw_set_req),
        .set_done     (set_done),
        .entry_en     (entry_en),
        .set_en       (set_en),
        .vga_status   (vga_status),
        .locked       (locked),
        .lock_secs    (lock_secs),
        .fail_cnt     (fail_cnt)
    );

    assign obs = {entry_en, set_en, vga_status, locked, lock_secs, fail_cnt};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: each timed state is a countdown of cycles
    task automatic model_reset();
        m_mode = M_SETUP;
        m_fail = 0;
        m_left = 0;
    endtask

    task automatic model_step(input logic vr, input logic vm, input logic ps, input logic sd);
        case (m_mode)
            M_SETUP: if (sd) begin m_mode = M_IDLE; m_fail = 0; end
            M_IDLE: begin
                if (vr) begin
                    if (vm) begin
                        m_mode = M_GRANT; m_fail = 0; m_left = GRANT_CYC;
                    end else if (m_fail + 1 >= MAX_FAIL) begin
                        m_mode = M_LOCK; m_fail = MAX_FAIL; m_left = LOCK_CYC;
                    end else begin
                        m_mode = M_DENY; m_fail = m_fail + 1; m_left = DENY_CYC;
                    end
                end
            end
            M_GRANT: begin
                if (ps && !vr) begin
                    m_mode = M_SETUP;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
            M_DENY: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_IDLE; m_fail = 0; end
            end
        endcase
    endtask

    function automatic logic [16:0] model_outs();
        logic       ee, se, lk;
        logic [1:0] v;
        logic [7:0] s;
        ee = (m_mode == M_SETUP) || (m_mode == M_IDLE);
        se = (m_mode == M_SETUP);
        lk = (m_mode == M_LOCK);
        case (m_mode)
            M_GRANT: v = 2'd1;
            M_DENY:  v = 2'd2;
            M_LOCK:  v = 2'd3;
            default: v = 2'd0;
        endcase
        s = lk ? 8'((m_left + CPS - 1) / CPS) : 8'd0;
        return {ee, se, v, lk, s, 4'(m_fail)};
    endfunction

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // driver: called at a negedge, returns at the next negedge
    task automatic cyc(input logic vr, input logic vm, input logic ps, input logic sd);
        verify_req   = vr;
        verify_match = vm;
        pw_set_req   = ps;
        set_done     = sd;
        @(posedge clk);
        model_step(vr, vm, ps, sd);
        @(negedge clk);
        verify_req   = 1'b0;
        verify_match = 1'b0;
        pw_set_req   = 1'b0;
        set_done     = 1'b0;
        chk("step", 32'(obs), 32'(model_outs()));
    endtask

    task automatic cyc_rand();
        cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst", 32'(obs), 32'(model_outs()));
        chk("async_rst_const", 32'(obs), 32'h18000);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        verify_req = 1'b0; verify_match = 1'b0; pw_set_req = 1'b0; set_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset", 32'(obs), 32'(model_outs()));
        chk("reset_en", 32'({entry_en, set_en}), 32'b11);
        rst = 1'b1;

        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 0);                 // ignored in SETUP
        cyc(0, 0, 0, 1);                 // SETUP -> IDLE
        chk("idle_set_en", 32'(set_en), 32'd0);
        cyc(0, 0, 1, 0);                 // pw_set_req ignored in IDLE
        chk("idle_pwset", 32'(set_en), 32'd0);

        // grant display length
        cyc(1, 1, 0, 0);
        chk("grant_vga", 32'(vga_status), 32'd1);
        n = 0;
        while (vga_status == 2'd1 && n < 100) begin n++; cyc(0, 0, 0, 0); end
        chk("grant_len", n, GRANT_CYC);
        chk("grant_exit_en", 32'(entry_en), 32'd1);

        // two denials, verify_req during DENIED ignored
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 0, 0);
            n = 0;
            while (vga_status == 2'd2 && n < 100) begin n++; cyc(1, 0, 0, 0); end
            chk("deny_len", n, DENY_CYC);
        end
        chk("fail_two", 32'(fail_cnt), 32'd2);

        // third mismatch -> lockout
        cyc(1, 0, 0, 0);
        chk("lock_secs_entry", 32'({vga_status, locked, lock_secs}), 32'({2'd3, 1'b1, 8'd2}));
        n = 0;
        while (locked && n < 30000) begin n++; cyc_rand(); end
        chk("lock_len", n, LOCK_CYC);
        chk("unlock_fail", 32'(fail_cnt), 32'd0);

        // password change from GRANTED
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("grant_to_setup", 32'(set_en), 32'd1);
        cyc(0, 0, 0, 1);

        // verify wins over simultaneous pw_set_req
        cyc(1, 0, 1, 0);
        chk("simul_deny", 32'({set_en, vga_status, fail_cnt}), 32'({1'b0, 2'd2, 4'd1}));
        while (m_mode != M_IDLE) cyc(0, 0, 0, 0);

        // lock again, then reset with one second left
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 0, 0);
            while (m_mode == M_DENY) cyc(0, 0, 0, 0);
        end
        n = 0;
        while (lock_secs != 8'd1 && n < 10100) begin n++; cyc(0, 0, 0, 0); end
        chk("reach_secs1", 32'(lock_secs), 32'd1);
        do_reset();

        // randomized phase
        locks = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc_rand();
            if (m_mode == M_LOCK) begin
                locks++;
                if (locks > 2) begin
                    do_reset();
                end else begin
                    n = 0;
                    while (m_mode == M_LOCK && n < 25000) begin n++; cyc_rand(); end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
